// File: rtl/fetch_pkg.sv
// Shared types and byte constants for the 8088 instruction assembler.
// FETCH_PREFIX_EN selects prefix collection in instruction_fetch.
package fetch_pkg;

  typedef enum logic [3:0] {
    PREFIX,
    MODRM,
    DISP_LO,
    DISP_HI,
    IMM0,
    IMM1,
    IMM2,
    IMM3,
    DONE
  } fetch_state_t;

  localparam logic [2:0] SEG_ES   = 3'd0;
  localparam logic [2:0] SEG_CS   = 3'd1;
  localparam logic [2:0] SEG_SS   = 3'd2;
  localparam logic [2:0] SEG_DS   = 3'd3;
  localparam logic [2:0] SEG_NONE = 3'b111;

  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;

  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_NE   = 2'b10;
  localparam logic [1:0] REP_E    = 2'b11;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PFX_ES) || (b == PFX_CS) || (b == PFX_SS) || (b == PFX_DS) ||
           (b == PFX_LOCK) || (b == PFX_REPNE) || (b == PFX_REP);
  endfunction

endpackage

// File: rtl/op_length_decode.sv
// Opcode length decode: reports whether a ModRM byte follows and the
// immediate size. F6/F7 only carry an immediate for the TEST form (reg=0).
module op_length_decode
  import fetch_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic [2:0] modrm_reg,
  output logic       has_modrm,
  output logic [2:0] imm_bytes
);

  always_comb begin
    has_modrm = 1'b0;
    imm_bytes = 3'd0;
    // Regular ALU block: r/m forms 0-3, accumulator-immediate forms 4/5
    if (opcode[7:6] == 2'b00) begin
      has_modrm = ~opcode[2];
      if (opcode[2:0] == 3'd4)      imm_bytes = 3'd1;
      else if (opcode[2:0] == 3'd5) imm_bytes = 3'd2;
    end
    case (opcode) inside
      [8'h80:8'h8F], [8'hC4:8'hC7], [8'hD0:8'hD3], [8'hD8:8'hDF],
      8'hF6, 8'hF7, 8'hFE, 8'hFF: has_modrm = 1'b1;
      default: ;
    endcase
    case (opcode) inside
      [8'h70:8'h7F], 8'h80, 8'h82, 8'h83, 8'hA8, [8'hB0:8'hB7], 8'hC6,
      8'hCD, 8'hD4, 8'hD5, [8'hE0:8'hE7], 8'hEB: imm_bytes = 3'd1;
      8'h81, [8'hA0:8'hA3], 8'hA9, [8'hB8:8'hBF], 8'hC2, 8'hC7, 8'hCA,
      8'hE8, 8'hE9: imm_bytes = 3'd2;
      8'h9A, 8'hEA: imm_bytes = 3'd4;
      8'hF6: if (modrm_reg == 3'd0) imm_bytes = 3'd1;
      8'hF7: if (modrm_reg == 3'd0) imm_bytes = 3'd2;
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Assembles 8088 instructions from the prefetch queue, one byte per two
// cycles, and hands records to the EU. Define FETCH_PREFIX_EN to fold prefixes.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned MAX_PREFIX = 4
) (
  input  logic        CLKx4,
  input  logic        RESET_n,
  input  logic [7:0]  prefetchTop,
  input  logic        prefetchEmpty,
  output logic        advanceTop,
  input  logic        flush,
  input  logic        inst_ack,
  output logic        inst_valid,
  output logic [7:0]  inst_opcode,
  output logic [7:0]  inst_modrm,
  output logic [15:0] inst_disp,
  output logic [31:0] inst_imm,
  output logic [3:0]  inst_len,
  output logic [2:0]  inst_seg,
  output logic [1:0]  inst_rep,
  output logic        inst_lock
);

  if (MAX_PREFIX < 1 || MAX_PREFIX > 15) begin : g_bad_max_prefix
    $error("MAX_PREFIX must be in 1..15");
  end

  fetch_state_t state, cur, nxt, after_disp;
  logic         gap, restart, take, has_modrm;
  logic [2:0]   imm_bytes, dec_reg, dm_rm;
  logic [1:0]   dm_mod, disp_bytes;
  logic [7:0]   dec_op;
  logic [3:0]   len_base;

  // An ack in DONE behaves as an immediate return to PREFIX, so the next
  // byte may be captured on the very edge that retires the record.
  assign restart  = (state == DONE) && inst_ack;
  assign cur      = restart ? PREFIX : state;
  assign len_base = restart ? 4'd0 : inst_len;
  assign take     = !flush && (cur != DONE) && !gap && !prefetchEmpty;

  assign dec_op  = (cur == PREFIX) ? prefetchTop : inst_opcode;
  assign dec_reg = (cur == MODRM) ? prefetchTop[5:3] : inst_modrm[5:3];
  assign dm_mod  = (cur == MODRM) ? prefetchTop[7:6] : inst_modrm[7:6];
  assign dm_rm   = (cur == MODRM) ? prefetchTop[2:0] : inst_modrm[2:0];

  op_length_decode u_decode (
    .opcode    (dec_op),
    .modrm_reg (dec_reg),
    .has_modrm (has_modrm),
    .imm_bytes (imm_bytes)
  );

  always_comb begin
    disp_bytes = 2'd0;
    case (dm_mod)
      2'b01:   disp_bytes = 2'd1;
      2'b10:   disp_bytes = 2'd2;
      2'b00:   if (dm_rm == 3'b110) disp_bytes = 2'd2;
      default: ;
    endcase
  end

  assign after_disp = (imm_bytes != 3'd0) ? IMM0 : DONE;

`ifdef FETCH_PREFIX_EN
  logic [3:0] pfx_cnt, pfx_base, pfx_next;

  assign pfx_base = restart ? 4'd0 : pfx_cnt;
  assign pfx_next = pfx_base + 4'd1;

  always_ff @(posedge CLKx4) begin
    if (!RESET_n || flush) begin
      inst_seg  <= SEG_NONE;
      inst_rep  <= REP_NONE;
      inst_lock <= 1'b0;
      pfx_cnt   <= '0;
    end else begin
      if (restart) begin
        inst_seg  <= SEG_NONE;
        inst_rep  <= REP_NONE;
        inst_lock <= 1'b0;
        pfx_cnt   <= '0;
      end
      if (take && cur == PREFIX && is_prefix(prefetchTop)) begin
        pfx_cnt <= pfx_next;
        case (prefetchTop)
          PFX_ES:    inst_seg  <= SEG_ES;
          PFX_CS:    inst_seg  <= SEG_CS;
          PFX_SS:    inst_seg  <= SEG_SS;
          PFX_DS:    inst_seg  <= SEG_DS;
          PFX_LOCK:  inst_lock <= 1'b1;
          PFX_REPNE: inst_rep  <= REP_NE;
          PFX_REP:   inst_rep  <= REP_E;
          default:   ;
        endcase
      end
    end
  end
`else
  assign inst_seg  = SEG_NONE;
  assign inst_rep  = REP_NONE;
  assign inst_lock = 1'b0;
`endif

  always_comb begin
    nxt = cur;
    if (take) begin
      case (cur)
        PREFIX: begin
`ifdef FETCH_PREFIX_EN
          if (is_prefix(prefetchTop))
            nxt = (32'(pfx_next) >= MAX_PREFIX) ? DONE : PREFIX;
          else
`endif
            nxt = has_modrm ? MODRM : after_disp;
        end
        MODRM:   nxt = (disp_bytes != 2'd0) ? DISP_LO : after_disp;
        DISP_LO: nxt = (disp_bytes == 2'd2) ? DISP_HI : after_disp;
        DISP_HI: nxt = after_disp;
        IMM0:    nxt = (imm_bytes == 3'd1) ? DONE : IMM1;
        IMM1:    nxt = (imm_bytes == 3'd2) ? DONE : IMM2;
        IMM2:    nxt = IMM3;
        IMM3:    nxt = DONE;
        default: nxt = cur;
      endcase
    end
  end

  always_ff @(posedge CLKx4) begin
    if (!RESET_n) begin
      state       <= PREFIX;
      gap         <= 1'b0;
      advanceTop  <= 1'b0;
      inst_valid  <= 1'b0;
      inst_opcode <= '0;
      inst_modrm  <= '0;
      inst_disp   <= '0;
      inst_imm    <= '0;
      inst_len    <= '0;
    end else begin
      gap        <= take;
      advanceTop <= take;
      state      <= flush ? PREFIX : nxt;
      inst_valid <= !flush && (nxt == DONE);
      if (flush || restart) begin
        inst_opcode <= '0;
        inst_modrm  <= '0;
        inst_disp   <= '0;
        inst_imm    <= '0;
        inst_len    <= '0;
      end
      if (take) begin
        inst_len <= len_base + 4'd1;
        case (cur)
          PREFIX:  inst_opcode     <= prefetchTop;
          MODRM:   inst_modrm      <= prefetchTop;
          DISP_LO: inst_disp       <= {{8{prefetchTop[7]}}, prefetchTop};
          DISP_HI: inst_disp[15:8] <= prefetchTop;
          IMM0:    inst_imm[7:0]   <= prefetchTop;
          IMM1:    inst_imm[15:8]  <= prefetchTop;
          IMM2:    inst_imm[23:16] <= prefetchTop;
          IMM3:    inst_imm[31:24] <= prefetchTop;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a modelled prefetch queue.
// Expectations follow FETCH_PREFIX_EN the same way the design does.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n, flush, inst_ack;
  logic [7:0]  prefetch_top;
  logic        prefetch_empty, advance_top, inst_valid, inst_lock;
  logic [7:0]  inst_opcode, inst_modrm;
  logic [15:0] inst_disp;
  logic [31:0] inst_imm;
  logic [3:0]  inst_len;
  logic [2:0]  inst_seg;
  logic [1:0]  inst_rep;
  logic [73:0] rec;

  logic [7:0]  mem [0:63];
  int unsigned rd = 0, wr = 0, cyc = 0, pulses = 0;
  int unsigned pulse_at [0:63];
  int          vectors = 0, miscompares = 0;

  localparam logic [73:0] REC_RESET = {8'h00, 8'h00, 16'h0000, 32'h0, 4'd0, 3'd7, 2'd0, 1'b0};

  always #5 clk = ~clk;

  instruction_fetch #(.MAX_PREFIX(4)) dut (
    .CLKx4        (clk),
    .RESET_n      (reset_n),
    .prefetchTop  (prefetch_top),
    .prefetchEmpty(prefetch_empty),
    .advanceTop   (advance_top),
    .flush        (flush),
    .inst_ack     (inst_ack),
    .inst_valid   (inst_valid),
    .inst_opcode  (inst_opcode),
    .inst_modrm   (inst_modrm),
    .inst_disp    (inst_disp),
    .inst_imm     (inst_imm),
    .inst_len     (inst_len),
    .inst_seg     (inst_seg),
    .inst_rep     (inst_rep),
    .inst_lock    (inst_lock)
  );

  assign rec            = {inst_opcode, inst_modrm, inst_disp, inst_imm, inst_len, inst_seg, inst_rep, inst_lock};
  assign prefetch_top   = mem[rd[5:0]];
  assign prefetch_empty = (rd == wr);

  // Queue pop and pulse log: advanceTop seen high at an edge pops the head.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (advance_top) begin
      if (rd != wr) rd <= rd + 1;
      pulse_at[pulses[5:0]] <= cyc;
      pulses <= pulses + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr[5:0]] = b;
    wr = wr + 1;
  endtask

  task automatic wait_valid(input int max, output bit got);
    for (int i = 0; i < max && !inst_valid; i++) tick();
    got = inst_valid;
  endtask

  task automatic ack_record();
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; inst_ack = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({advance_top, inst_valid, rec} !== {2'b00, REC_RESET}) begin
      $display("FAIL reset_state: got %h want %h", {advance_top, inst_valid, rec}, {2'b00, REC_RESET});
      miscompares++;
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    int unsigned n0 = pulses;
    push(8'h90);
    tick();
    vectors++;
    if ({advance_top, inst_valid} !== 2'b11) begin
      $display("FAIL single_timing: adv/valid got %b want 11", {advance_top, inst_valid});
      miscompares++;
    end
    vectors++;
    if (rec !== {8'h90, 8'h00, 16'h0000, 32'h0, 4'd1, 3'd7, 2'd0, 1'b0}) begin
      $display("FAIL single_rec: got %h want %h", rec, {8'h90, 8'h00, 16'h0000, 32'h0, 4'd1, 3'd7, 2'd0, 1'b0});
      miscompares++;
    end
    tick();
    vectors++;
    if ({advance_top, inst_valid} !== 2'b01) begin
      $display("FAIL single_pulse_end: adv/valid got %b want 01", {advance_top, inst_valid});
      miscompares++;
    end
    ack_record();
    vectors++;
    if ({inst_valid, rec} !== {1'b0, REC_RESET}) begin
      $display("FAIL single_ack_clear: got %h want %h", {inst_valid, rec}, {1'b0, REC_RESET});
      miscompares++;
    end
    vectors++;
    if (pulses - n0 != 1) begin
      $display("FAIL single_pulses: got %0d want 1", pulses - n0);
      miscompares++;
    end
  endtask

  task automatic test_seg_override();
    int unsigned n0 = pulses;
    bit got;
    push(8'h2E); push(8'h8B); push(8'h47); push(8'hFE);
`ifdef FETCH_PREFIX_EN
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'h8B, 8'h47, 16'hFFFE, 32'h0, 4'd4, 3'd1, 2'd0, 1'b0}) begin
      $display("FAIL seg_rec: valid %b got %h want %h", got, rec, {8'h8B, 8'h47, 16'hFFFE, 32'h0, 4'd4, 3'd1, 2'd0, 1'b0});
      miscompares++;
    end
    tick();
    vectors++;
    if (pulses - n0 != 4 || pulse_at[(n0 + 3) % 64] - pulse_at[n0 % 64] != 6) begin
      $display("FAIL seg_pulse_spacing: count %0d span %0d want 4/6", pulses - n0, pulse_at[(n0 + 3) % 64] - pulse_at[n0 % 64]);
      miscompares++;
    end
`else
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'h2E, 8'h00, 16'h0000, 32'h0, 4'd1, 3'd7, 2'd0, 1'b0}) begin
      $display("FAIL seg_prefix_alone: valid %b got %h want %h", got, rec, {8'h2E, 8'h00, 16'h0000, 32'h0, 4'd1, 3'd7, 2'd0, 1'b0});
      miscompares++;
    end
    ack_record();
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'h8B, 8'h47, 16'hFFFE, 32'h0, 4'd3, 3'd7, 2'd0, 1'b0}) begin
      $display("FAIL seg_rec: valid %b got %h want %h", got, rec, {8'h8B, 8'h47, 16'hFFFE, 32'h0, 4'd3, 3'd7, 2'd0, 1'b0});
      miscompares++;
    end
    tick();
    vectors++;
    if (pulses - n0 != 4 || pulse_at[(n0 + 3) % 64] - pulse_at[(n0 + 1) % 64] != 4) begin
      $display("FAIL seg_pulse_spacing: count %0d span %0d want 4/4", pulses - n0, pulse_at[(n0 + 3) % 64] - pulse_at[(n0 + 1) % 64]);
      miscompares++;
    end
`endif
    ack_record();
    vectors++;
    if (inst_valid !== 1'b0) begin
      $display("FAIL seg_ack: valid got %b want 0", inst_valid);
      miscompares++;
    end
  endtask

  task automatic test_far_imm();
    bit got;
    push(8'hEA); push(8'h34); push(8'h12); push(8'h00); push(8'hF0);
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'hEA, 8'h00, 16'h0000, 32'hF0001234, 4'd5, 3'd7, 2'd0, 1'b0}) begin
      $display("FAIL far_imm_rec: valid %b got %h want %h", got, rec, {8'hEA, 8'h00, 16'h0000, 32'hF0001234, 4'd5, 3'd7, 2'd0, 1'b0});
      miscompares++;
    end
    tick();
    ack_record();
  endtask

  task automatic test_modrm_disp_imm();
    bit got;
    push(8'hC7); push(8'h06); push(8'h10); push(8'h00); push(8'hAD); push(8'hDE);
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'hC7, 8'h06, 16'h0010, 32'h0000DEAD, 4'd6, 3'd7, 2'd0, 1'b0}) begin
      $display("FAIL disp_imm_rec: valid %b got %h want %h", got, rec, {8'hC7, 8'h06, 16'h0010, 32'h0000DEAD, 4'd6, 3'd7, 2'd0, 1'b0});
      miscompares++;
    end
    tick();
    ack_record();
  endtask

  task automatic test_empty_stall();
    int unsigned n0 = pulses;
    int unsigned n1;
    bit got;
    push(8'hC7); push(8'h06); push(8'h10);
    repeat (26) tick();
    vectors++;
    if ({inst_valid, rec} !== {1'b0, 8'hC7, 8'h06, 16'h0010, 32'h0, 4'd3, 3'd7, 2'd0, 1'b0} || pulses - n0 != 3) begin
      $display("FAIL stall_hold: got %h pulses %0d want %h pulses 3", {inst_valid, rec}, pulses - n0,
               {1'b0, 8'hC7, 8'h06, 16'h0010, 32'h0, 4'd3, 3'd7, 2'd0, 1'b0});
      miscompares++;
    end
    n1 = pulses;
    push(8'h00); push(8'hAD); push(8'hDE);
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'hC7, 8'h06, 16'h0010, 32'h0000DEAD, 4'd6, 3'd7, 2'd0, 1'b0}) begin
      $display("FAIL stall_rec: valid %b got %h want %h", got, rec, {8'hC7, 8'h06, 16'h0010, 32'h0000DEAD, 4'd6, 3'd7, 2'd0, 1'b0});
      miscompares++;
    end
    tick();
    vectors++;
    if (pulses - n1 != 3) begin
      $display("FAIL stall_resume_pulses: got %0d want 3", pulses - n1);
      miscompares++;
    end
    ack_record();
  endtask

  task automatic test_flush();
    int unsigned n0 = pulses;
    bit got;
    push(8'hF3); push(8'hA4);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if ({inst_valid, rec} !== {1'b0, REC_RESET}) begin
      $display("FAIL flush_clear: got %h want %h", {inst_valid, rec}, {1'b0, REC_RESET});
      miscompares++;
    end
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'hA4, 8'h00, 16'h0000, 32'h0, 4'd1, 3'd7, 2'd0, 1'b0}) begin
      $display("FAIL flush_next_rec: valid %b got %h want %h", got, rec, {8'hA4, 8'h00, 16'h0000, 32'h0, 4'd1, 3'd7, 2'd0, 1'b0});
      miscompares++;
    end
    tick();
    vectors++;
    if (pulses - n0 != 2) begin
      $display("FAIL flush_pulses: got %0d want 2", pulses - n0);
      miscompares++;
    end
    ack_record();
  endtask

  task automatic test_prefix_mode();
    bit got;
    push(8'hF3); push(8'hA4);
`ifdef FETCH_PREFIX_EN
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'hA4, 8'h00, 16'h0000, 32'h0, 4'd2, 3'd7, 2'b11, 1'b0}) begin
      $display("FAIL rep_rec: valid %b got %h want %h", got, rec, {8'hA4, 8'h00, 16'h0000, 32'h0, 4'd2, 3'd7, 2'b11, 1'b0});
      miscompares++;
    end
    tick();
    ack_record();
    push(8'h26); push(8'hF0); push(8'hF2); push(8'h3E);
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'h3E, 8'h00, 16'h0000, 32'h0, 4'd4, 3'd3, 2'b10, 1'b1}) begin
      $display("FAIL prefix_limit_rec: valid %b got %h want %h", got, rec, {8'h3E, 8'h00, 16'h0000, 32'h0, 4'd4, 3'd3, 2'b10, 1'b1});
      miscompares++;
    end
    tick();
    ack_record();
`else
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'hF3, 8'h00, 16'h0000, 32'h0, 4'd1, 3'd7, 2'd0, 1'b0}) begin
      $display("FAIL rep_alone_rec: valid %b got %h want %h", got, rec, {8'hF3, 8'h00, 16'h0000, 32'h0, 4'd1, 3'd7, 2'd0, 1'b0});
      miscompares++;
    end
    ack_record();
    wait_valid(40, got);
    vectors++;
    if (!got || rec !== {8'hA4, 8'h00, 16'h0000, 32'h0, 4'd1, 3'd7, 2'd0, 1'b0}) begin
      $display("FAIL rep_second_rec: valid %b got %h want %h", got, rec, {8'hA4, 8'h00, 16'h0000, 32'h0, 4'd1, 3'd7, 2'd0, 1'b0});
      miscompares++;
    end
    tick();
    ack_record();
`endif
  endtask

  task automatic test_reset_mid();
    int unsigned n0 = pulses;
    push(8'hC7); push(8'h06);
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    vectors++;
    if ({advance_top, inst_valid, rec} !== {2'b00, REC_RESET}) begin
      $display("FAIL reset_mid: got %h want %h", {advance_top, inst_valid, rec}, {2'b00, REC_RESET});
      miscompares++;
    end
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    vectors++;
    if (pulses - n0 != 2 || advance_top !== 1'b0) begin
      $display("FAIL reset_mid_pulses: got %0d adv %b want 2 adv 0", pulses - n0, advance_top);
      miscompares++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_seg_override();
    test_far_imm();
    test_modrm_disp_imm();
    test_empty_stall();
    test_flush();
    test_prefix_mode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
